iic_master_core: RTL and testbench

IIC_MASTER_CORE -- requirements
Module: iic_master_core

---
 rtl/iic_master_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_iic_master_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_master_core.sv
// rtl/iic_master_core.sv - I2C master: write phase, optional repeated-start read phase, stop
//
// Purpose: runs one I2C transaction per accepted START_I. It writes WR_BYTE_NUM_I bytes
// (byte 0 is the address). If RD_BYTE_NUM_I is non-zero, it then issues a repeated start,
// resends the address with R/W = 1 and reads RD_BYTE_NUM_I bytes. It ends with a stop.
//
// Ports:
//   CLK_I          clock, rising edge
//   RSTN_I         asynchronous active-low reset
//   WR_BYTE_NUM_I  bytes to write including the address byte (1..8)
//   WR_DATA_I      write bytes, byte k at [8k+7:8k]
//   RD_BYTE_NUM_I  bytes to read after the write phase (0..8)
//   START_I        one-cycle request, taken only when idle
//   RD_DATA_O      read bytes, byte k at [8k+7:8k]
//   BUSY_O         transaction in progress (includes the accepting cycle)
//   FINISH_O       one-cycle completion pulse
//   ERROR_O        valid with FINISH_O: NACK seen or request invalid
//   SCL_T, SDA_T   open-drain enables, 1 = released, 0 = pull low
//   SDA_I          sampled SDA level
module iic_master_core #(
  parameter int C_QTR = 250
) (
  input  logic        CLK_I,
  input  logic        RSTN_I,
  input  logic [7:0]  WR_BYTE_NUM_I,
  input  logic [63:0] WR_DATA_I,
  input  logic [7:0]  RD_BYTE_NUM_I,
  input  logic        START_I,
  output logic [63:0] RD_DATA_O,
  output logic        BUSY_O,
  output logic        FINISH_O,
  output logic        ERROR_O,
  output logic        SCL_T,
  output logic        SDA_T,
  input  logic        SDA_I
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_START, S_WR_BIT, S_WR_ACK,
    S_RSTART, S_RD_BIT, S_RD_ACK, S_STOP, S_DONE
  } state_t;

  localparam int CW = (C_QTR > 1) ? $clog2(C_QTR) : 1;

  state_t      state;
  logic [CW-1:0] qcnt;
  logic        tick;
  logic [1:0]  qtr;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic [7:0]  wr_num;
  logic [7:0]  rd_num;
  logic [63:0] wr_data;
  logic        rd_phase;   // address byte being resent for the read phase
  logic        ack_smp;
  logic        err_flag;
  logic        busy_reg;
  logic [7:0]  rx_shift;
  logic [7:0]  tx_byte;
  logic        tx_bit;
  logic        last_wr;
  logic        last_rd;
  logic        invalid;
  logic        scl_nx;
  logic        sda_nx;

  assign tick    = (qcnt == CW'(C_QTR - 1));
  assign tx_byte = rd_phase ? {wr_data[7:1], 1'b1} : wr_data[{byte_idx, 3'b000} +: 8];
  assign tx_bit  = tx_byte[~bit_idx];  // ~bit_idx == 7 - bit_idx: MSB first
  assign last_wr = ({5'd0, byte_idx} == wr_num - 8'd1);
  assign last_rd = ({5'd0, byte_idx} == rd_num - 8'd1);
  assign invalid = (wr_num == 8'd0) || (wr_num > 8'd8) || (rd_num > 8'd8);
  assign BUSY_O  = busy_reg | START_I;

  // Line levels wanted for the current state/quarter; registered below, so the
  // bus lags the state by one clock uniformly.
  always_comb begin
    scl_nx = 1'b1;
    sda_nx = 1'b1;
    case (state)
      S_START: begin
        scl_nx = (qtr == 2'd0);
        sda_nx = 1'b0;
      end
      S_WR_BIT: begin
        scl_nx = (qtr == 2'd1) || (qtr == 2'd2);
        sda_nx = tx_bit;
      end
      S_WR_ACK, S_RD_BIT: begin
        scl_nx = (qtr == 2'd1) || (qtr == 2'd2);
        sda_nx = 1'b1;
      end
      S_RD_ACK: begin
        scl_nx = (qtr == 2'd1) || (qtr == 2'd2);
        sda_nx = last_rd;  // ACK all but the final byte
      end
      S_RSTART: begin
        // q0 release SDA, q1 release SCL, q2 SDA low, q3 SCL low
        scl_nx = (qtr == 2'd1) || (qtr == 2'd2);
        sda_nx = (qtr < 2'd2);
      end
      S_STOP: begin
        scl_nx = (qtr != 2'd0);
        sda_nx = (qtr == 2'd2);
      end
      default: begin
        scl_nx = 1'b1;
        sda_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      qtr       <= 2'd0;
      bit_idx   <= 3'd0;
      byte_idx  <= 3'd0;
      wr_num    <= 8'd0;
      rd_num    <= 8'd0;
      wr_data   <= 64'd0;
      rd_phase  <= 1'b0;
      ack_smp   <= 1'b0;
      err_flag  <= 1'b0;
      busy_reg  <= 1'b0;
      rx_shift  <= 8'd0;
      RD_DATA_O <= 64'd0;
      FINISH_O  <= 1'b0;
      ERROR_O   <= 1'b0;
      SCL_T     <= 1'b1;
      SDA_T     <= 1'b1;
    end else begin
      SCL_T    <= scl_nx;
      SDA_T    <= sda_nx;
      FINISH_O <= 1'b0;
      ERROR_O  <= 1'b0;
      qcnt     <= tick ? '0 : qcnt + 1'b1;
      if (tick) qtr <= qtr + 2'd1;

      case (state)
        S_IDLE: begin
          qcnt <= '0;
          qtr  <= 2'd0;
          if (START_I) begin
            wr_num    <= WR_BYTE_NUM_I;
            rd_num    <= RD_BYTE_NUM_I;
            wr_data   <= WR_DATA_I;
            RD_DATA_O <= 64'd0;
            err_flag  <= 1'b0;
            busy_reg  <= 1'b1;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          qtr <= 2'd0;
          if (invalid) begin
            FINISH_O <= 1'b1;
            ERROR_O  <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_START;
          end
        end
        S_START: begin
          if (tick && qtr == 2'd1) begin
            qtr      <= 2'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            rd_phase <= 1'b0;
            state    <= S_WR_BIT;
          end
        end
        S_WR_BIT: begin
          if (tick && qtr == 2'd3) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (tick && qtr == 2'd2) ack_smp <= SDA_I;
          if (tick && qtr == 2'd3) begin
            if (ack_smp) begin
              err_flag <= 1'b1;
              state    <= S_STOP;
            end else if (rd_phase) begin
              byte_idx <= 3'd0;
              state    <= S_RD_BIT;
            end else if (last_wr) begin
              state <= (rd_num == 8'd0) ? S_STOP : S_RSTART;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= S_WR_BIT;
            end
          end
        end
        S_RSTART: begin
          if (tick && qtr == 2'd3) begin
            rd_phase <= 1'b1;
            bit_idx  <= 3'd0;
            state    <= S_WR_BIT;
          end
        end
        S_RD_BIT: begin
          if (tick && qtr == 2'd2) rx_shift <= {rx_shift[6:0], SDA_I};
          if (tick && qtr == 2'd3) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              RD_DATA_O[{byte_idx, 3'b000} +: 8] <= rx_shift;
              state <= S_RD_ACK;
            end
          end
        end
        S_RD_ACK: begin
          if (tick && qtr == 2'd3) begin
            if (last_rd) begin
              state <= S_STOP;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= S_RD_BIT;
            end
          end
        end
        S_STOP: begin
          if (tick && qtr == 2'd2) begin
            qtr      <= 2'd0;
            FINISH_O <= 1'b1;
            ERROR_O  <= err_flag;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          busy_reg <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_master_core.sv
// tb/tb_iic_master_core.sv - directed self-checking bench for iic_master_core with an I2C slave responder
module tb_iic_master_core;
  localparam int QTR = 4;

  logic        CLK_I = 1'b0;
  logic        RSTN_I;
  logic [7:0]  WR_BYTE_NUM_I;
  logic [63:0] WR_DATA_I;
  logic [7:0]  RD_BYTE_NUM_I;
  logic        START_I;
  logic [63:0] RD_DATA_O;
  logic        BUSY_O;
  logic        FINISH_O;
  logic        ERROR_O;
  logic        SCL_T;
  logic        SDA_T;
  logic        SDA_I;

  logic        slv_sda = 1'b1;
  assign SDA_I = SDA_T & slv_sda;

  always #5 CLK_I = ~CLK_I;

  iic_master_core #(.C_QTR(QTR)) dut (
    .CLK_I(CLK_I), .RSTN_I(RSTN_I), .WR_BYTE_NUM_I(WR_BYTE_NUM_I), .WR_DATA_I(WR_DATA_I),
    .RD_BYTE_NUM_I(RD_BYTE_NUM_I), .START_I(START_I), .RD_DATA_O(RD_DATA_O), .BUSY_O(BUSY_O),
    .FINISH_O(FINISH_O), .ERROR_O(ERROR_O), .SCL_T(SCL_T), .SDA_T(SDA_T), .SDA_I(SDA_I)
  );

  int checks = 0;
  int errors = 0;

  // Slave responder / bus monitor state
  logic       clr_req = 1'b0;
  int         nack_at = -1;
  logic [7:0] rd_src [0:7];
  logic       p_scl = 1'b1, p_sda = 1'b1;
  int         bitc = 0, rd_n = 0;
  logic [7:0] shreg = 8'd0, rdb = 8'd0;
  logic       first = 1'b0, pend = 1'b0, rd_act = 1'b0, last_mack = 1'b0;
  int         n_start = 0, n_stop = 0, n_bytes = 0, n_mack = 0, n_fin = 0, scl_rises = 0;
  logic       lines_low = 1'b0;
  logic [7:0] byte_log [0:15];
  logic       mack_log [0:7];

  always @(negedge CLK_I) begin
    p_scl <= SCL_T;
    p_sda <= SDA_I;
    if (FINISH_O) n_fin <= n_fin + 1;
    if (!SCL_T || !SDA_T) lines_low <= 1'b1;
    if (!RSTN_I) begin
      bitc <= 0; first <= 1'b0; pend <= 1'b0; rd_act <= 1'b0; slv_sda <= 1'b1;
    end else if (p_scl && SCL_T && p_sda && !SDA_I) begin
      n_start <= n_start + 1;
      bitc <= 0; first <= 1'b1; pend <= 1'b0; rd_act <= 1'b0; slv_sda <= 1'b1;
    end else if (p_scl && SCL_T && !p_sda && SDA_I) begin
      n_stop <= n_stop + 1;
      bitc <= 0; first <= 1'b0; pend <= 1'b0; rd_act <= 1'b0; slv_sda <= 1'b1;
    end else if (!p_scl && SCL_T) begin
      scl_rises <= scl_rises + 1;
      if (bitc < 8) begin
        if (!rd_act) shreg <= {shreg[6:0], SDA_I};
        bitc <= bitc + 1;
      end else if (bitc == 8) begin
        if (rd_act) begin
          if (n_mack < 8) mack_log[n_mack] <= SDA_I;
          n_mack <= n_mack + 1;
          last_mack <= SDA_I;
        end
        bitc <= 9;
      end
    end else if (p_scl && !SCL_T) begin
      if (bitc == 8) begin
        if (!rd_act) begin
          if (n_bytes < 16) byte_log[n_bytes] <= shreg;
          n_bytes <= n_bytes + 1;
          slv_sda <= (n_bytes == nack_at);
          if (first && shreg[0]) pend <= 1'b1;
          first <= 1'b0;
        end else begin
          slv_sda <= 1'b1;
        end
      end else if (bitc == 9) begin
        bitc <= 0;
        if (pend) begin
          pend <= 1'b0; rd_act <= 1'b1; rd_n <= 0;
          rdb <= rd_src[0]; slv_sda <= rd_src[0][7];
        end else if (rd_act && !last_mack) begin
          rd_n <= rd_n + 1;
          rdb <= rd_src[(rd_n + 1) % 8]; slv_sda <= rd_src[(rd_n + 1) % 8][7];
        end else begin
          rd_act <= 1'b0; slv_sda <= 1'b1;
        end
      end else if (bitc >= 1 && bitc <= 7 && rd_act) begin
        slv_sda <= rdb[3'(7 - bitc)];
      end
    end
    if (clr_req) begin
      n_start <= 0; n_stop <= 0; n_bytes <= 0; n_mack <= 0; n_fin <= 0;
      scl_rises <= 0; lines_low <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK_I);
      #1;
    end
  endtask

  task automatic clear_logs();
    clr_req = 1'b1;
    cyc(1);
    clr_req = 1'b0;
  endtask

  // Pulse START_I for one cycle; BUSY_O must already be high in that cycle.
  task automatic request(input logic [7:0] wr, input logic [63:0] data, input logic [7:0] rd);
    WR_BYTE_NUM_I = wr;
    WR_DATA_I     = data;
    RD_BYTE_NUM_I = rd;
    START_I       = 1'b1;
    #1;
    chk("busy_start_cycle", 64'(BUSY_O), 64'd1);
    cyc(1);
    START_I = 1'b0;
  endtask

  task automatic wait_finish(input string tag, output logic err);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      cyc(1);
      if (FINISH_O === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_finished"}, 64'(got), 64'd1);
    err = ERROR_O;
  endtask

  logic e;
  logic reached;
  logic [7:0] inv_wr [0:2];
  logic [7:0] inv_rd [0:2];

  initial begin
    RSTN_I = 1'b0; START_I = 1'b0; WR_BYTE_NUM_I = 8'd0; WR_DATA_I = 64'd0; RD_BYTE_NUM_I = 8'd0;
    for (int i = 0; i < 8; i++) rd_src[i] = 8'h00;
    inv_wr[0] = 8'd0; inv_rd[0] = 8'd0;
    inv_wr[1] = 8'd1; inv_rd[1] = 8'd9;
    inv_wr[2] = 8'd9; inv_rd[2] = 8'd0;
    #12;
    chk("rst_scl", 64'(SCL_T), 64'd1);
    chk("rst_sda", 64'(SDA_T), 64'd1);
    chk("rst_busy", 64'(BUSY_O), 64'd0);
    chk("rst_finish", 64'(FINISH_O), 64'd0);
    chk("rst_error", 64'(ERROR_O), 64'd0);
    chk("rst_rd_data", RD_DATA_O, 64'd0);
    cyc(3);
    RSTN_I = 1'b1;
    cyc(2);

    // Write three bytes, all ACKed
    clear_logs();
    request(8'd3, 64'h0000_0000_0055_AAA0, 8'd0);
    chk("wr_busy_after_accept", 64'(BUSY_O), 64'd1);
    wait_finish("wr", e);
    chk("wr_error", 64'(e), 64'd0);
    cyc(4);
    chk("wr_nbytes", 64'(n_bytes), 64'd3);
    chk("wr_byte0", 64'(byte_log[0]), 64'hA0);
    chk("wr_byte1", 64'(byte_log[1]), 64'hAA);
    chk("wr_byte2", 64'(byte_log[2]), 64'h55);
    chk("wr_nstart", 64'(n_start), 64'd1);
    chk("wr_nstop", 64'(n_stop), 64'd1);
    chk("wr_rd_data", RD_DATA_O, 64'd0);
    chk("wr_nfinish", 64'(n_fin), 64'd1);
    chk("wr_busy_end", 64'(BUSY_O), 64'd0);

    // Write A0,10 then repeated start and read two bytes
    rd_src[0] = 8'h3C; rd_src[1] = 8'h7E;
    clear_logs();
    request(8'd2, 64'h0000_0000_0000_10A0, 8'd2);
    wait_finish("rd", e);
    chk("rd_error", 64'(e), 64'd0);
    cyc(4);
    chk("rd_nbytes", 64'(n_bytes), 64'd3);
    chk("rd_byte1", 64'(byte_log[1]), 64'h10);
    chk("rd_addr", 64'(byte_log[2]), 64'hA1);
    chk("rd_nstart", 64'(n_start), 64'd2);
    chk("rd_nstop", 64'(n_stop), 64'd1);
    chk("rd_nmack", 64'(n_mack), 64'd2);
    chk("rd_mack0", 64'(mack_log[0]), 64'd0);
    chk("rd_mack1", 64'(mack_log[1]), 64'd1);
    chk("rd_data", RD_DATA_O, 64'h0000_0000_0000_7E3C);

    // Slave NACKs byte 1 of four
    nack_at = 1;
    clear_logs();
    request(8'd4, 64'h0000_0000_3322_10A0, 8'd0);
    wait_finish("nack", e);
    chk("nack_error", 64'(e), 64'd1);
    cyc(4);
    nack_at = -1;
    chk("nack_nbytes", 64'(n_bytes), 64'd2);
    chk("nack_byte1", 64'(byte_log[1]), 64'h10);
    chk("nack_nstop", 64'(n_stop), 64'd1);
    chk("nack_scl_rises", 64'(scl_rises), 64'd19);

    // Invalid requests: no bus activity, FINISH/ERROR two cycles after START
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      request(inv_wr[i], 64'h0000_0000_0000_00A0, inv_rd[i]);
      chk($sformatf("inv%0d_finish_c1", i), 64'(FINISH_O), 64'd0);
      cyc(1);
      chk($sformatf("inv%0d_finish_c2", i), 64'(FINISH_O), 64'd1);
      chk($sformatf("inv%0d_error_c2", i), 64'(ERROR_O), 64'd1);
      cyc(1);
      chk($sformatf("inv%0d_finish_c3", i), 64'(FINISH_O), 64'd0);
      cyc(3);
      chk($sformatf("inv%0d_lines_quiet", i), 64'(lines_low), 64'd0);
      chk($sformatf("inv%0d_nfinish", i), 64'(n_fin), 64'd1);
    end

    // Second START while busy is ignored
    clear_logs();
    request(8'd1, 64'h0000_0000_0000_00A0, 8'd0);
    cyc(50);
    WR_BYTE_NUM_I = 8'd2; WR_DATA_I = 64'h0000_0000_0000_FFA0; RD_BYTE_NUM_I = 8'd0;
    START_I = 1'b1;
    #1;
    chk("dbl_busy_second", 64'(BUSY_O), 64'd1);
    cyc(1);
    START_I = 1'b0;
    wait_finish("dbl", e);
    chk("dbl_error", 64'(e), 64'd0);
    cyc(300);
    chk("dbl_nfinish", 64'(n_fin), 64'd1);
    chk("dbl_nbytes", 64'(n_bytes), 64'd1);
    chk("dbl_byte0", 64'(byte_log[0]), 64'hA0);
    chk("dbl_busy_end", 64'(BUSY_O), 64'd0);

    // Reset during the read data phase
    rd_src[0] = 8'h00;
    clear_logs();
    request(8'd1, 64'h0000_0000_0000_00A0, 8'd1);
    reached = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (n_bytes >= 2) begin
        reached = 1'b1;
        break;
      end
      cyc(1);
    end
    chk("rst_mid_reached_read", 64'(reached), 64'd1);
    cyc(40);
    for (int k = 0; k < 20; k++) begin
      if (SCL_T === 1'b0) break;
      cyc(1);
    end
    chk("rst_mid_scl_low_before", 64'(SCL_T), 64'd0);
    RSTN_I = 1'b0;
    #1;
    chk("rst_mid_scl", 64'(SCL_T), 64'd1);
    chk("rst_mid_sda", 64'(SDA_T), 64'd1);
    chk("rst_mid_busy", 64'(BUSY_O), 64'd0);
    cyc(3);
    RSTN_I = 1'b1;
    cyc(5);
    chk("rst_mid_nfinish", 64'(n_fin), 64'd0);
    clear_logs();
    request(8'd2, 64'h0000_0000_0000_5AA0, 8'd0);
    wait_finish("post_rst", e);
    chk("post_rst_error", 64'(e), 64'd0);
    cyc(4);
    chk("post_rst_nbytes", 64'(n_bytes), 64'd2);
    chk("post_rst_byte1", 64'(byte_log[1]), 64'h5A);
    chk("post_rst_nfinish", 64'(n_fin), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
